dmem_access_ctrl: RTL and testbench

Sequencer for the data-memory access in the MEM stage: turns a load/store in MEM into a multi-cycle req/ready bus transaction, holds the MEM/WB pipeline register and upstream stages via `hold` until the access completes, and delivers aligned, sign/zero-extended load data as MEM/WB's `read_data`. It sits between the EX/MEM outputs and the MEM/WB register, replacing any direct combinational memory read.

---
 rtl/dmem_pkg.sv | 29 ++
 rtl/dmem_load_ext.sv | 31 +++
 rtl/dmem_access_ctrl.sv | 139 +++++++++++++
 tb/tb_dmem_access_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, size codes and bus-lane helpers for the MEM-stage data memory sequencer.
package dmem_pkg;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [1:0] LS_B = 2'b00;
  localparam logic [1:0] LS_H = 2'b01;
  localparam logic [1:0] LS_W = 2'b10;

  localparam int TIMEOUT_W = 8;

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      LS_B:    byte_en = 4'b0001 << a;
      LS_H:    byte_en = 4'b0011 << {a[1], 1'b0};
      default: byte_en = 4'hF;
    endcase
  endfunction

  // Narrow stores are replicated so every enabled lane carries the datum.
  function automatic logic [31:0] store_lanes(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      LS_B:    store_lanes = {4{d[7:0]}};
      LS_H:    store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load lane select and sign/zero extension of the raw bus read word.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_b;
  logic [15:0] w_h;
  logic        w_sgn;

  always_comb begin
    case (i_lane)
      2'd0:    w_b = i_rdata[7:0];
      2'd1:    w_b = i_rdata[15:8];
      2'd2:    w_b = i_rdata[23:16];
      default: w_b = i_rdata[31:24];
    endcase
    w_h   = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_sgn = ~i_funct3[2];
    case (i_funct3[1:0])
      LS_B:    o_data = {{24{w_sgn & w_b[7]}}, w_b};
      LS_H:    o_data = {{16{w_sgn & w_h[15]}}, w_h};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data memory sequencer: IDLE/BUSY/DONE req/ready handshake with pipeline hold.
// Optional BUSY watchdog enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_readM,
  input  logic        mem_writeM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic [31:0] read_data,
  output logic        hold,
  output logic        misalign,
  output logic        timeout
);

  state_e      r_state, w_next;
  logic        r_req, r_we, r_timeout;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic [2:0]  r_f3;
  logic [1:0]  r_lane;
  logic        w_access, w_abort, w_bad;
  logic [31:0] w_ext;

  always_comb begin
    case (funct3M[1:0])
      LS_H:    w_bad = addrM[0];
      LS_W:    w_bad = |addrM[1:0];
      LS_B:    w_bad = 1'b0;
      default: w_bad = 1'b1;
    endcase
  end

  assign misalign = (mem_readM | mem_writeM) & w_bad;
  assign w_access = (mem_readM | mem_writeM) & ~misalign;

`ifdef DMEM_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_cnt;
  assign w_abort = (r_state == S_BUSY) & ~bus_ready & (r_cnt == TIMEOUT_W'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_cnt <= '0;
    else if (r_state == S_IDLE)                 r_cnt <= '0;
    else if (r_state == S_BUSY && !bus_ready)   r_cnt <= r_cnt + 1'b1;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC != 0);
  assign w_abort      = 1'b0;
`endif

  dmem_load_ext u_ext (
    .i_rdata  (bus_rdata),
    .i_lane   (r_lane),
    .i_funct3 (r_f3),
    .o_data   (w_ext)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_access) w_next = S_BUSY;
      S_BUSY:  if (bus_ready || w_abort) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Hold is forced low during reset so the pipeline is released with the bus.
  always_comb begin
    hold = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE:  hold = w_access;
        S_BUSY:  hold = 1'b1;
        default: hold = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
      r_f3      <= '0;
      r_lane    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_access) begin
          r_req   <= 1'b1;
          r_we    <= mem_writeM;
          r_addr  <= {addrM[31:2], 2'b00};
          r_be    <= byte_en(funct3M[1:0], addrM[1:0]);
          r_wdata <= store_lanes(funct3M[1:0], wdataM);
          r_f3    <= funct3M;
          r_lane  <= addrM[1:0];
        end
        S_BUSY: if (bus_ready) begin
          r_req   <= 1'b0;
          r_rdata <= r_we ? 32'h0 : w_ext;
        end else if (w_abort) begin
          r_req     <= 1'b0;
          r_rdata   <= 32'h0;
          r_timeout <= 1'b1;
        end
        default: r_timeout <= 1'b0;
      endcase
    end
  end

  assign bus_req   = r_req;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_be    = r_be;
  assign read_data = r_rdata;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed vector bench for dmem_access_ctrl (default build, watchdog disabled).
module tb_dmem_access_ctrl;

  logic        clk, rst;
  logic        mem_readM, mem_writeM;
  logic [2:0]  funct3M;
  logic [31:0] addrM, wdataM;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ready;
  logic [31:0] bus_rdata, read_data;
  logic        hold, misalign, timeout;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst), .mem_readM(mem_readM), .mem_writeM(mem_writeM),
    .funct3M(funct3M), .addrM(addrM), .wdataM(wdataM),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .read_data(read_data), .hold(hold), .misalign(misalign), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          waits;
    logic        mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd;
    int          exp_hold;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_readM = 0; mem_writeM = 0; funct3M = 0; addrM = 0; wdataM = 0;
    bus_ready = 0; bus_rdata = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int hc, bn;
    @(negedge clk);
    mem_readM = v.rd; mem_writeM = v.wr; funct3M = v.f3; addrM = v.addr;
    wdataM = v.wdata; bus_rdata = v.rdata; bus_ready = 0;
    #1;
    chk($sformatf("v%0d misalign", idx), 32'(misalign), 32'(v.mis));
    if (v.mis) begin
      chk($sformatf("v%0d mis hold", idx), 32'(hold), 0);
      for (int c = 0; c < 3; c++) begin
        bus_ready = 1;
        @(posedge clk); #1;
        chk($sformatf("v%0d mis req c%0d", idx, c), 32'(bus_req), 0);
        chk($sformatf("v%0d mis hold c%0d", idx, c), 32'(hold), 0);
      end
      idle_inputs();
      return;
    end
    hc = 0; bn = 0;
    while (hold && hc < 100) begin
      @(posedge clk); #1;
      hc++;
      if (bus_req) begin
        chk($sformatf("v%0d addr", idx), bus_addr, v.exp_addr);
        chk($sformatf("v%0d be", idx), 32'(bus_be), 32'(v.exp_be));
        chk($sformatf("v%0d we", idx), 32'(bus_we), 32'(v.wr));
        if (v.wr) chk($sformatf("v%0d wdata", idx), bus_wdata, v.exp_wd);
        bus_ready = (bn == v.waits);
        bn++;
      end else begin
        bus_ready = 0;
      end
    end
    chk($sformatf("v%0d hold cycles", idx), hc, v.exp_hold);
    chk($sformatf("v%0d done req", idx), 32'(bus_req), 0);
    chk($sformatf("v%0d read_data", idx), read_data, v.exp_rd);
    chk($sformatf("v%0d timeout", idx), 32'(timeout), 0);
    idle_inputs();
    @(posedge clk); #1;
    chk($sformatf("v%0d idle hold", idx), 32'(hold), 0);
    chk($sformatf("v%0d rd stable", idx), read_data, v.exp_rd);
  endtask

  initial begin
    //          rd wr f3      addr          wdata          rdata        w  mis exp_addr      be       exp_wd         exp_rd        hold
    vecs[0]  = '{1, 0, 3'b010, 32'h104, 32'h55555555, 32'hDEADBEEF, 0, 0, 32'h104, 4'b1111, 32'h55555555, 32'hDEADBEEF, 2};
    vecs[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,        32'h80112233, 1, 0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80, 3};
    vecs[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,        32'h80112233, 0, 0, 32'h100, 4'b1000, 32'h0,        32'h00000080, 2};
    vecs[3]  = '{0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 3, 0, 32'h200, 4'b1100, 32'hABCDABCD, 32'h0,        5};
    vecs[4]  = '{1, 0, 3'b001, 32'h106, 32'h0,        32'h80017FFF, 0, 0, 32'h104, 4'b1100, 32'h0,        32'hFFFF8001, 2};
    vecs[5]  = '{1, 0, 3'b101, 32'h104, 32'h0,        32'h8001F00F, 2, 0, 32'h104, 4'b0011, 32'h0,        32'h0000F00F, 4};
    vecs[6]  = '{0, 1, 3'b000, 32'h301, 32'h123456A5, 32'h0,        0, 0, 32'h300, 4'b0010, 32'hA5A5A5A5, 32'h0,        2};
    vecs[7]  = '{0, 1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0,        1, 0, 32'h400, 4'b1111, 32'hCAFEF00D, 32'h0,        3};
    vecs[8]  = '{1, 1, 3'b010, 32'h500, 32'h11223344, 32'h99999999, 0, 0, 32'h500, 4'b1111, 32'h11223344, 32'h0,        2};
    vecs[9]  = '{1, 0, 3'b000, 32'h000, 32'h0,        32'h0000007F, 0, 0, 32'h000, 4'b0001, 32'h0,        32'h0000007F, 2};
    vecs[10] = '{1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        0};
    vecs[11] = '{1, 0, 3'b001, 32'h103, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        0};
    vecs[12] = '{1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        0};
    vecs[13] = '{0, 1, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        0};

    idle_inputs();
    rst = 1;
    #12;
    chk("rst bus_req", 32'(bus_req), 0);
    chk("rst bus_we", 32'(bus_we), 0);
    chk("rst bus_addr", bus_addr, 0);
    chk("rst bus_wdata", bus_wdata, 0);
    chk("rst bus_be", 32'(bus_be), 0);
    chk("rst read_data", read_data, 0);
    chk("rst timeout", 32'(timeout), 0);
    chk("rst hold", 32'(hold), 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // bus_ready outside BUSY must not disturb anything
    @(negedge clk);
    bus_ready = 1; bus_rdata = 32'h12345678;
    repeat (2) @(posedge clk);
    #1;
    chk("stray ready req", 32'(bus_req), 0);
    chk("stray ready rd", read_data, 32'h7F);
    idle_inputs();

    // reset in the middle of a BUSY wait
    @(negedge clk);
    mem_readM = 1; funct3M = 3'b010; addrM = 32'h108; bus_rdata = 32'hAAAA5555;
    @(posedge clk); #1;
    chk("mid busy req", 32'(bus_req), 1);
    chk("mid busy rd held", read_data, 32'h7F);
    rst = 1;
    #1;
    chk("mid rst req", 32'(bus_req), 0);
    chk("mid rst hold", 32'(hold), 0);
    chk("mid rst read_data", read_data, 0);
    idle_inputs();
    @(negedge clk);
    rst = 0;
    run_vec(vecs[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

endmodule
